// File: rtl/audio_pkg.sv
// Shared audio-path constants: sample width, record FIFO depth, PicoBlaze port IDs.
package audio_pkg;

    localparam int          SAMPLE_W       = 16;
    localparam int          AUD_FIFO_DEPTH = 16;
    localparam logic [7:0]  PORT_ID_LEVEL  = 8'h06;
    localparam logic [7:0]  PORT_ID_OVF    = 8'h07;

endpackage

// File: rtl/audio_sample_fifo_if.sv
// Show-ahead valid/ready stream from the record FIFO to the RAM write FSM.
interface audio_sample_fifo_if #(
    parameter int DATA_W = audio_pkg::SAMPLE_W
);

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/audio_fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read (distributed RAM).
module audio_fifo_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/audio_sample_fifo.sv
// Record-path sample FIFO between codec and RAM writer, with sticky overflow.
// Optional saturating drop counter enabled by defining AUDIO_FIFO_DROP_CNT_EN.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter  int DATA_W = SAMPLE_W,
    parameter  int DEPTH  = AUD_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sample_end,
    input  logic [DATA_W-1:0]    audio_input_sample,
    input  logic                 flush,
    audio_sample_fifo_if.master  rd_if,
    output logic [ADDR_W:0]      level,
    output logic                 full,
    output logic                 overflow,
    input  logic                 overflow_clr,
    output logic [7:0]           drop_count
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic            push_req, push, pop, drop;

    // Extra pointer MSB distinguishes full from empty; the difference is the occupancy.
    assign level           = wr_ptr - rd_ptr;
    assign full            = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                             (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign rd_if.out_valid = (wr_ptr != rd_ptr);

    assign push_req = sample_end & enable;
    assign pop      = rd_if.out_valid & rd_if.out_ready;
    assign push     = push_req & (~full | pop);
    // A sample lost to a flush is not an overflow.
    assign drop     = push_req & full & ~pop & ~flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)             overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (overflow_clr) overflow <= 1'b0;
    end

`ifdef AUDIO_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt <= 8'h00;
        else if (overflow_clr)
            drop_cnt <= drop ? 8'h01 : 8'h00;
        else if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'h01;
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = 8'h00;
`endif

    audio_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush & ~reset),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (audio_input_sample),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rd_if.out_data)
    );

endmodule
